// File: rtl/mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_refill_arbiter
//  Description : Shares the single main-memory port between the instruction-
//                cache refill path and the data-cache miss/store path. Grants
//                one transaction at a time (round-robin on ties), counts the
//                read beats of a line burst and steers them to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_refill_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          ic_req_i,
  input  logic [ADDR_W-1:0]             ic_addr_i,
  input  logic                          ic_abort_i,
  input  logic                          dc_req_i,
  input  logic                          dc_we_i,
  input  logic [ADDR_W-1:0]             dc_addr_i,
  input  logic [DATA_W-1:0]             dc_wdata_i,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          ic_beat_o,
  output logic                          dc_beat_o,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx_o,
  output logic                          ic_done_o,
  output logic                          dc_done_o
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                abort_pending_q, abort_pending_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                grant_dc;

  // A flushed fetch must not win arbitration in the cycle it is flushed
  logic w_ic_ok;
  logic w_beat;
  assign w_ic_ok = ic_req_i && !ic_abort_i;
  assign w_beat  = (state_q == S_BURST) && mem_rvalid_i;

  // Next-state: arbitration in IDLE, handshake in ISSUE, beat counting in BURST
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    abort_pending_d = abort_pending_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    grant_dc        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_ic_ok || dc_req_i) begin
          // DC wins when alone, or on a tie when IC was served last
          grant_dc        = dc_req_i && (!w_ic_ok || (last_grant_q == OWN_IC));
          owner_d         = grant_dc ? OWN_DC : OWN_IC;
          last_grant_d    = grant_dc ? OWN_DC : OWN_IC;
          addr_d          = grant_dc ? dc_addr_i : ic_addr_i;
          we_d            = grant_dc && dc_we_i;
          wdata_d         = grant_dc ? dc_wdata_i : '0;
          abort_pending_d = 1'b0;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The request stays up even if flushed: memory cannot recall it
        if (owner_q == OWN_IC && ic_abort_i) abort_pending_d = 1'b1;
        if (mem_ready_i) begin
          cnt_d   = '0;
          state_d = we_q ? S_DONE : S_BURST;
        end
      end
      S_BURST: begin
        if (owner_q == OWN_IC && ic_abort_i) abort_pending_d = 1'b1;
        if (mem_rvalid_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = S_DONE;
        end
      end
      default: begin
        abort_pending_d = 1'b0;
        state_d         = S_IDLE;
      end
    endcase
  end

  // State and context registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_IC;
      last_grant_q    <= OWN_IC;
      abort_pending_q <= 1'b0;
      cnt_q           <= '0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      abort_pending_q <= abort_pending_d;
      cnt_q           <= cnt_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
    end
  end

  // Memory request side is only driven while the request is outstanding
  assign mem_req_o   = (state_q == S_ISSUE);
  assign mem_we_o    = (state_q == S_ISSUE) && we_q;
  assign mem_addr_o  = (state_q == S_ISSUE) ? addr_q  : '0;
  assign mem_wdata_o = (state_q == S_ISSUE) ? wdata_q : '0;

  // Beat steering; a flushed refill is drained silently, including the flush cycle
  assign rdata_o    = mem_rdata_i;
  assign ic_beat_o  = w_beat && (owner_q == OWN_IC) && !abort_pending_q && !ic_abort_i;
  assign dc_beat_o  = w_beat && (owner_q == OWN_DC);
  assign beat_idx_o = cnt_q;
  assign ic_done_o  = (state_q == S_DONE) && (owner_q == OWN_IC) && !abort_pending_q;
  assign dc_done_o  = (state_q == S_DONE) && (owner_q == OWN_DC);

endmodule
`default_nettype wire

// File: tb/tb_mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_refill_arbiter
//  Description : Directed self-checking bench for mem_refill_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_refill_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ic_req_i, ic_abort_i, dc_req_i, dc_we_i;
  logic [31:0] ic_addr_i, dc_addr_i, dc_wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i, rdata_o;
  logic        ic_beat_o, dc_beat_o, ic_done_o, dc_done_o;
  logic [1:0]  beat_idx_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_refill_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_abort_i(ic_abort_i),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rdata_o(rdata_o), .ic_beat_o(ic_beat_o), .dc_beat_o(dc_beat_o), .beat_idx_o(beat_idx_o),
    .ic_done_o(ic_done_o), .dc_done_o(dc_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},    mem_req_o,   0);
    check({tag, "_we"},     mem_we_o,    0);
    check({tag, "_addr"},   mem_addr_o,  0);
    check({tag, "_wdata"},  mem_wdata_o, 0);
    check({tag, "_icbeat"}, ic_beat_o,   0);
    check({tag, "_dcbeat"}, dc_beat_o,   0);
    check({tag, "_idx"},    beat_idx_o,  0);
    check({tag, "_icdone"}, ic_done_o,   0);
    check({tag, "_dcdone"}, dc_done_o,   0);
  endtask

  // Called with the arbiter in ISSUE: accepts the request and returns four beats
  task automatic serve_refill(input bit to_dc, input logic [31:0] base);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    check("burst_req_low", mem_req_o, 0);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = base + i;
      #1;
      check("ic_beat",  ic_beat_o,  !to_dc);
      check("dc_beat",  dc_beat_o,  to_dc);
      check("beat_idx", beat_idx_o, i);
      check("rdata",    rdata_o,    base + i);
      tick();
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    #1;
    check("ic_done", ic_done_o, !to_dc);
    check("dc_done", dc_done_o, to_dc);
  endtask

  initial begin
    reset_i = 1'b1; ic_req_i = 0; ic_abort_i = 0; dc_req_i = 0; dc_we_i = 0;
    ic_addr_i = '0; dc_addr_i = '0; dc_wdata_i = '0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    tick(); tick();
    check_idle_outputs("reset");
    reset_i = 1'b0;
    tick();

    // Tie straight after reset: DC first, then IC, then DC again
    ic_req_i = 1; ic_addr_i = 32'h100;
    dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h300;
    tick();
    check("tie1_req",  mem_req_o,  1);
    check("tie1_addr", mem_addr_o, 32'h300);
    check("tie1_we",   mem_we_o,   0);
    serve_refill(1'b1, 32'hB0);
    dc_req_i = 0;
    tick();
    check("tie_turn_req", mem_req_o, 0);
    check("tie_turn_dcdone", dc_done_o, 0);
    tick();
    check("tie2_req",  mem_req_o,  1);
    check("tie2_addr", mem_addr_o, 32'h100);
    serve_refill(1'b0, 32'hB4);
    dc_req_i = 1;
    tick();
    tick();
    check("tie3_addr", mem_addr_o, 32'h300);
    serve_refill(1'b1, 32'hB8);
    ic_req_i = 0; dc_req_i = 0;
    tick();
    check_idle_outputs("tie_end");

    // IC-only refill, memory accepts one cycle after the request appears
    ic_req_i = 1; ic_addr_i = 32'h100;
    tick();
    check("ic_req",  mem_req_o,  1);
    check("ic_addr", mem_addr_o, 32'h100);
    check("ic_we",   mem_we_o,   0);
    tick();
    check("ic_req_hold", mem_req_o, 1);
    serve_refill(1'b0, 32'hA0);
    ic_req_i = 0;
    tick();
    check("ic_done_pulse", ic_done_o, 0);

    // DC store with acceptance delayed three cycles
    dc_req_i = 1; dc_we_i = 1; dc_addr_i = 32'h2004; dc_wdata_i = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("st_req",   mem_req_o,   1);
      check("st_we",    mem_we_o,    1);
      check("st_addr",  mem_addr_o,  32'h2004);
      check("st_wdata", mem_wdata_o, 32'hDEADBEEF);
      tick();
    end
    mem_ready_i = 1;
    #1;
    check("st_req_acc", mem_req_o, 1);
    tick();
    mem_ready_i = 0;
    check("st_done",   dc_done_o, 1);
    check("st_req_lo", mem_req_o, 0);
    check("st_dcbeat", dc_beat_o, 0);
    dc_req_i = 0; dc_we_i = 0;
    tick();
    check("st_done_pulse", dc_done_o, 0);

    // Flush after beat 1 of an IC refill; queued DC refill follows
    ic_req_i = 1; ic_addr_i = 32'h400;
    tick();
    check("ab_addr", mem_addr_o, 32'h400);
    dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h500;
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid_i = 1; mem_rdata_i = 32'hD0 + i;
      #1;
      check("ab_beat_pre", ic_beat_o, 1);
      check("ab_idx_pre",  beat_idx_o, i);
      tick();
    end
    ic_abort_i = 1; ic_req_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hD2;
    #1;
    check("ab_beat2",   ic_beat_o, 0);
    check("ab_dcbeat2", dc_beat_o, 0);
    check("ab_idx2",    beat_idx_o, 2);
    tick();
    ic_abort_i = 0;
    mem_rdata_i = 32'hD3;
    #1;
    check("ab_beat3", ic_beat_o, 0);
    check("ab_idx3",  beat_idx_o, 3);
    tick();
    mem_rvalid_i = 0;
    check("ab_no_icdone", ic_done_o, 0);
    check("ab_no_dcdone", dc_done_o, 0);
    tick();
    check("ab_idle", mem_req_o, 0);
    tick();
    check("ab_dc_req",  mem_req_o,  1);
    check("ab_dc_addr", mem_addr_o, 32'h500);
    serve_refill(1'b1, 32'hC0);
    dc_req_i = 0;
    tick();

    // Stray read beats in IDLE and ISSUE
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    #1;
    check("stray_idle_ic",  ic_beat_o,  0);
    check("stray_idle_dc",  dc_beat_o,  0);
    check("stray_idle_idx", beat_idx_o, 0);
    tick();
    ic_req_i = 1; ic_addr_i = 32'h600;
    tick();
    check("stray_issue_ic",  ic_beat_o,  0);
    check("stray_issue_dc",  dc_beat_o,  0);
    tick();
    check("stray_issue_idx", beat_idx_o, 0);
    check("stray_issue_req", mem_req_o,  1);
    mem_rvalid_i = 0;
    serve_refill(1'b0, 32'hE0);
    ic_req_i = 0;
    tick();

    // Reset during a burst, after beat 2
    ic_req_i = 1; ic_addr_i = 32'h700;
    tick();
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1; mem_rdata_i = 32'h70 + i;
      #1;
      check("rst_pre_idx", beat_idx_o, i);
      tick();
    end
    mem_rvalid_i = 0; reset_i = 1; ic_req_i = 0;
    tick();
    check_idle_outputs("rst_mid");
    reset_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h73;
    #1;
    check("rst_stray_ic",  ic_beat_o,  0);
    check("rst_stray_idx", beat_idx_o, 0);
    tick();
    check("rst_stray_ic2",  ic_beat_o,  0);
    check("rst_stray_idx2", beat_idx_o, 0);
    mem_rvalid_i = 0;
    ic_req_i = 1; ic_addr_i = 32'h800;
    tick();
    check("rst_fresh_addr", mem_addr_o, 32'h800);
    serve_refill(1'b0, 32'hF0);
    ic_req_i = 0;
    tick();
    check_idle_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
